// File: rtl/ram_boot_loader_pkg.sv
// Shared encodings for the RAM boot loader and the datapath bus fields.
package ram_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN0    = 3'd1,
    LEN1    = 3'd2,
    COLLECT = 3'd3,
    WRITE   = 3'd4,
    VERIFY  = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

  localparam logic [1:0]  SIZE_DWORD = 2'b11;
  localparam logic [1:0]  RAM_CS     = 2'b01;
  localparam logic [31:0] GPIO_DIR   = 32'd254;
  localparam logic [31:0] GPIO_RW    = 32'd255;

endpackage

// File: rtl/ram_boot_loader_packer.sv
// Assembles a little-endian stream of bytes into a 64-bit doubleword.
module byte_packer_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [63:0] word_o,
  output logic        word_full_o
);

  logic [2:0]  idx_q, idx_d;
  logic [63:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (push_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d                        = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = push_i && !clear_i && (idx_q == 3'd7);

endmodule

// File: rtl/ram_boot_loader.sv
// Boot loader: streams a counted image into RAM as doublewords, verifying each by readback.
module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_data_out,
  output logic              mem_data_oe,
  input  logic [63:0]       mem_data_in,
  output logic [1:0]        mem_cs,
  output logic              mem_write_en,
  output logic              mem_read,
  output logic [1:0]        size,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_written
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   ww_q, ww_d;
  logic               xfer, push, pk_clear, word_full;
  logic [63:0]        word;
  logic               bus_d;

  logic               in_ready_q, hold_q, done_q, error_q;
  logic [ADDR_W-1:0]  mem_address_q;
  logic [63:0]        mem_data_out_q;
  logic               mem_data_oe_q, mem_write_en_q, mem_read_q;
  logic [1:0]         mem_cs_q, size_q;

  logic               unused_base_lsbs;
  assign unused_base_lsbs = ^base_addr[2:0];

  byte_packer_64 u_packer (
    .clk         (clock),
    .rst_n       (reset),
    .clear_i     (pk_clear),
    .push_i      (push),
    .byte_i      (in_data),
    .word_o      (word),
    .word_full_o (word_full)
  );

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    n_d      = n_q;
    ww_d     = ww_q;
    push     = 1'b0;
    pk_clear = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d  = LEN0;
          addr_d   = {base_addr[ADDR_W-1:3], 3'b000};
          ww_d     = '0;
          pk_clear = 1'b1;
        end
      end
      LEN0: begin
        if (xfer) begin
          n_d     = CNT_W'(in_data);
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          n_d     = CNT_W'({in_data, n_q[7:0]});
          state_d = (n_d == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        push = xfer;
        if (word_full) state_d = WRITE;
      end
      WRITE: state_d = VERIFY;
      VERIFY: begin
        if (mem_data_in != word) begin
          state_d = ERROR;
        end else begin
          ww_d    = ww_q + CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(8);
          state_d = (ww_d == n_q) ? DONE : COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_d = (state_d == WRITE) || (state_d == VERIFY);

  // Outputs are decoded from the next state so they line up with state_q.
  // The packer's top lane is still being written on the WRITE entry edge,
  // so the write data is merged here from the incoming byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      n_q            <= '0;
      ww_q           <= '0;
      in_ready_q     <= 1'b0;
      hold_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      mem_data_oe_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_cs_q       <= '0;
      size_q         <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      n_q            <= n_d;
      ww_q           <= ww_d;
      in_ready_q     <= state_d inside {LEN0, LEN1, COLLECT};
      hold_q         <= state_d inside {LEN0, LEN1, COLLECT, WRITE, VERIFY};
      done_q         <= (state_d == DONE);
      error_q        <= (state_d == ERROR);
      mem_address_q  <= bus_d ? addr_d : '0;
      mem_data_out_q <= (state_d == WRITE) ? {in_data, word[55:0]} : '0;
      mem_data_oe_q  <= (state_d == WRITE);
      mem_write_en_q <= (state_d == WRITE);
      mem_read_q     <= (state_d == VERIFY);
      mem_cs_q       <= bus_d ? RAM_CS : '0;
      size_q         <= bus_d ? SIZE_DWORD : '0;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_address   = mem_address_q;
  assign mem_data_out  = mem_data_out_q;
  assign mem_data_oe   = mem_data_oe_q;
  assign mem_cs        = mem_cs_q;
  assign mem_write_en  = mem_write_en_q;
  assign mem_read      = mem_read_q;
  assign size          = size_q;
  assign cpu_hold      = hold_q;
  assign busy          = hold_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Directed bench for ram_boot_loader with a 64-bit RAM model on the bus.
`timescale 1ns/1ps
module tb_ram_boot_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] mem_address;
  logic [63:0] mem_data_out;
  logic        mem_data_oe;
  logic [63:0] mem_data_in;
  logic [1:0]  mem_cs;
  logic        mem_write_en;
  logic        mem_read;
  logic [1:0]  size;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int tests = 0;
  int fails = 0;

  logic [63:0] ram [0:127];
  logic [31:0] wr_addr [$];
  logic [63:0] wr_data [$];
  int          hold_viol = 0;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;
  bit          poke_start = 1'b0;

  localparam logic [63:0] W0 = 64'h0706050403020100;
  localparam logic [63:0] W1 = 64'h1716151413121110;
  localparam logic [63:0] W2 = 64'hA7A6A5A4A3A2A1A0;
  localparam logic [63:0] WS = 64'h8877665544332211;

  always #5 clock = ~clock;

  ram_boot_loader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_oe(mem_data_oe),
    .mem_data_in(mem_data_in), .mem_cs(mem_cs), .mem_write_en(mem_write_en),
    .mem_read(mem_read), .size(size), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error), .words_written(words_written)
  );

  always @(posedge clock) begin
    if (reset && mem_write_en) begin
      ram[mem_address[9:3]] <= mem_data_out;
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_data_out);
    end
    if ((mem_write_en || mem_read) && !cpu_hold) hold_viol <= hold_viol + 1;
  end

  always_comb begin
    logic [63:0] rd;
    rd = ram[mem_address[9:3]];
    if (corrupt_en && mem_address == corrupt_addr) rd = rd ^ 64'h20;
    mem_data_in = mem_read ? rd : '0;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int unsigned t;
    t = 0;
    if (gappy) begin
      while ($urandom_range(1, 0) == 0) begin
        in_valid = 1'b0;
        start = poke_start && ($urandom_range(1, 0) == 1);
        tick();
      end
      start = 1'b0;
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input bit gappy);
    for (int j = 0; j < 8; j++) send_byte(w[8*j +: 8], gappy);
  endtask

  task automatic wait_end();
    int unsigned t;
    t = 0;
    while (!(done || error) && t < 200) begin
      tick();
      t++;
    end
    tests++;
    if (!(done || error)) begin
      fails++;
      $display("FAIL wait_end_timeout: done=%0b error=%0b required one set", done, error);
    end
  endtask

  task automatic check_writes(input string name, input logic [31:0] a0, input logic [63:0] d0,
                              input int idx);
    tests++;
    if (wr_addr.size() <= idx) begin
      fails++;
      $display("FAIL %s_present: writes=%0d required >%0d", name, wr_addr.size(), idx);
    end else if (wr_addr[idx] !== a0 || wr_data[idx] !== d0) begin
      fails++;
      $display("FAIL %s: addr=%h data=%h required addr=%h data=%h",
               name, wr_addr[idx], wr_data[idx], a0, d0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    tests++;
    if ({in_ready, cpu_hold, busy, done, error} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 00000", {in_ready, cpu_hold, busy, done, error});
    end
    tests++;
    if (words_written !== 16'd0) begin
      fails++;
      $display("FAIL reset_ww: got %0d required 0", words_written);
    end
    tests++;
    if ({mem_address, mem_data_out, mem_data_oe, mem_cs, mem_write_en, mem_read, size} !== '0) begin
      fails++;
      $display("FAIL reset_bus: addr=%h data=%h oe=%b cs=%b we=%b rd=%b size=%b required all 0",
               mem_address, mem_data_out, mem_data_oe, mem_cs, mem_write_en, mem_read, size);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    wr_addr.delete();
    wr_data.delete();
    pulse_start(32'h100);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(WS, 1'b0);
    tests++;
    if ({mem_write_en, mem_data_oe, mem_cs, size, in_ready, mem_read} !== 8'b1_1_01_11_0_0) begin
      fails++;
      $display("FAIL single_write_ctl: we=%b oe=%b cs=%b size=%b rdy=%b rd=%b required 1 1 01 11 0 0",
               mem_write_en, mem_data_oe, mem_cs, size, in_ready, mem_read);
    end
    tests++;
    if (mem_address !== 32'h100 || mem_data_out !== WS) begin
      fails++;
      $display("FAIL single_write_bus: addr=%h data=%h required 00000100 %h",
               mem_address, mem_data_out, WS);
    end
    tick();
    tests++;
    if ({mem_read, mem_write_en, mem_data_oe, mem_cs} !== 5'b1_0_0_01 || mem_address !== 32'h100) begin
      fails++;
      $display("FAIL single_verify_ctl: rd=%b we=%b oe=%b cs=%b addr=%h required 1 0 0 01 00000100",
               mem_read, mem_write_en, mem_data_oe, mem_cs, mem_address);
    end
    tick();
    tests++;
    if ({done, error, cpu_hold, busy, mem_read} !== 5'b10000 || words_written !== 16'd1) begin
      fails++;
      $display("FAIL single_end: done=%b err=%b hold=%b busy=%b rd=%b ww=%0d required 1 0 0 0 0 ww=1",
               done, error, cpu_hold, busy, mem_read, words_written);
    end
    tests++;
    if (wr_addr.size() !== 1) begin
      fails++;
      $display("FAIL single_count: writes=%0d required 1", wr_addr.size());
    end
    check_writes("single_data", 32'h100, WS, 0);
  endtask

  task automatic run_three(input string name, input bit gappy);
    wr_addr.delete();
    wr_data.delete();
    pulse_start(32'h7);
    tests++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s_hold_start: hold=%b busy=%b done=%b required 1 1 0", name, cpu_hold, busy, done);
    end
    base_addr = 32'h300;
    if (gappy) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    send_byte(8'h03, gappy);
    send_byte(8'h00, gappy);
    if (gappy) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    send_word(W0, gappy);
    send_word(W1, gappy);
    send_word(W2, gappy);
    wait_end();
    tests++;
    if (wr_addr.size() !== 3) begin
      fails++;
      $display("FAIL %s_count: writes=%0d required 3", name, wr_addr.size());
    end
    check_writes({name, "_w0"}, 32'h0, W0, 0);
    check_writes({name, "_w1"}, 32'h8, W1, 1);
    check_writes({name, "_w2"}, 32'h10, W2, 2);
    tests++;
    if ({done, error, cpu_hold} !== 3'b100 || words_written !== 16'd3 || hold_viol !== 0) begin
      fails++;
      $display("FAIL %s_end: done=%b err=%b hold=%b ww=%0d hold_viol=%0d required 1 0 0 ww=3 viol=0",
               name, done, error, cpu_hold, words_written, hold_viol);
    end
  endtask

  task automatic test_multi_word();
    run_three("multi", 1'b0);
  endtask

  task automatic test_zero_len();
    wr_addr.delete();
    wr_data.delete();
    pulse_start(32'h400);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    tests++;
    if ({done, cpu_hold, in_ready} !== 3'b100 || words_written !== 16'd0) begin
      fails++;
      $display("FAIL zero_end: done=%b hold=%b rdy=%b ww=%0d required 1 0 0 ww=0",
               done, cpu_hold, in_ready, words_written);
    end
    tick();
    tick();
    tests++;
    if (wr_addr.size() !== 0) begin
      fails++;
      $display("FAIL zero_writes: writes=%0d required 0", wr_addr.size());
    end
  endtask

  task automatic test_mismatch();
    wr_addr.delete();
    wr_data.delete();
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h208;
    pulse_start(32'h200);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(W0, 1'b0);
    send_word(W1, 1'b0);
    wait_end();
    in_data  = 8'h5A;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    in_valid = 1'b0;
    tests++;
    if ({error, done, cpu_hold, in_ready} !== 4'b1000 || words_written !== 16'd1) begin
      fails++;
      $display("FAIL mismatch_end: err=%b done=%b hold=%b rdy=%b ww=%0d required 1 0 0 0 ww=1",
               error, done, cpu_hold, in_ready, words_written);
    end
    tests++;
    if (wr_addr.size() !== 2) begin
      fails++;
      $display("FAIL mismatch_count: writes=%0d required 2", wr_addr.size());
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    poke_start = 1'b1;
    run_three("gappy", 1'b1);
    poke_start = 1'b0;
  endtask

  task automatic test_async_abort();
    wr_addr.delete();
    wr_data.delete();
    pulse_start(32'h40);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int j = 0; j < 4; j++) send_byte(8'hC0 + 8'(j), 1'b0);
    in_data  = 8'hC4;
    in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({cpu_hold, in_ready, busy} !== 3'b000) begin
      fails++;
      $display("FAIL abort_same_cycle: hold=%b rdy=%b busy=%b required 000", cpu_hold, in_ready, busy);
    end
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if ({cpu_hold, in_ready, done, error} !== 4'b0000 || words_written !== 16'd0) begin
      fails++;
      $display("FAIL abort_idle: hold=%b rdy=%b done=%b err=%b ww=%0d required 0000 ww=0",
               cpu_hold, in_ready, done, error, words_written);
    end
    pulse_start(32'h40);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(W1, 1'b0);
    wait_end();
    tests++;
    if (wr_addr.size() !== 1 || done !== 1'b1 || words_written !== 16'd1) begin
      fails++;
      $display("FAIL abort_rerun: writes=%0d done=%b ww=%0d required 1 1 1",
               wr_addr.size(), done, words_written);
    end
    check_writes("abort_rerun_data", 32'h40, W1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_zero_len();
    test_mismatch();
    test_back_to_back();
    test_async_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
